fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
Time-multiplexed controller for one fully-connected layer. It computes Z[i] = B[i] + sum over j of X[j]*W[i][j] using a single fixed-point multiply-accumulate lane. It streams operands from external single-port read memories (X, W, B) and writes each result to a Z memory. It sits between the layer-level scheduler (start/done handshake) and the activation and weight buffers, replacing the fully-parallel FC array where area matters.

Parameters:
WORD_SIZE, 16, operand/result width, two's complement fixed point
INT_SLICE, 8, integer bits; DEC_SLICE = WORD_SIZE-INT_SLICE fraction bits
IN_SIZE, 128, input vector length (>=2)
OUT_SIZE, 128, output vector length (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin layer; sampled only in IDLE
busy  out  1  high from the first cycle after start is accepted until done
done  out  1  one-cycle pulse, layer complete
x_rd_en  out  1  X memory read strobe
x_addr  out  clog2(IN_SIZE)  X index j
x_data  in  WORD_SIZE  X[x_addr], valid 1 cycle after x_rd_en
w_rd_en  out  1  W memory read strobe
w_addr  out  clog2(IN_SIZE*OUT_SIZE)  i*IN_SIZE+j
w_data  in  WORD_SIZE  valid 1 cycle after w_rd_en
b_rd_en  out  1  B read strobe
b_addr  out  clog2(OUT_SIZE)  index i
b_data  in  WORD_SIZE  valid 1 cycle after b_rd_en
z_we  out  1  Z write strobe
z_addr  out  clog2(OUT_SIZE)  index i
z_data  out  WORD_SIZE  result Z[i]

Behaviour:
- Reset, asynchronous: state IDLE; i, j and acc cleared; all outputs 0.
- FSM states and transitions:
  - IDLE: if start, go to LOAD_B with i=0.
  - LOAD_B: b_rd_en=1, b_addr=i; go to MAC with j=0.
  - MAC: x_rd_en=w_rd_en=1, x_addr=j, w_addr=i*IN_SIZE+j.
    - At j=0: acc <= b_data.
    - At j>0: acc <= acc + prod(x_data,w_data) for element j-1.
    - At j=IN_SIZE-1: go to DRAIN.
  - DRAIN: acc <= acc + prod for the last element; go to WRITE.
  - WRITE: z_we=1, z_addr=i, z_data=acc. If i=OUT_SIZE-1 go to DONE, else i++ and go to LOAD_B.
  - DONE: done=1, busy=0; go to IDLE.
- Memory-driving outputs, z_data and done are registered. Strobes are 0 outside their states.
- Latency: each row takes IN_SIZE+3 cycles. The DONE state is entered OUT_SIZE*(IN_SIZE+3) rising edges after the edge that samples start.
- prod(a,b):
  - Form the full 2*WORD_SIZE signed product p.
  - If p is negative: take bits [WORD_SIZE+INT_SLICE-1 : DEC_SLICE] of -p, then negate.
  - Otherwise take the same slice of p.
  - Net effect is truncation toward zero.
- acc is WORD_SIZE bits; all additions wrap modulo 2^WORD_SIZE; no saturation.
- start while busy, or in DONE, is ignored. start held high in IDLE after done starts a new layer.
- rst_n low mid-layer: immediate return to IDLE, no further strobes, no partial Z write. The next start recomputes from i=0.
- Memory data inputs are ignored in any cycle not covered by the schedule above.

Decomposition:
- Package fc_pkg: state enum {IDLE, LOAD_B, MAC, DRAIN, WRITE, DONE}, default WORD_SIZE/INT_SLICE constants.
- Sub-module fc_fx_mul: combinational signed multiply with truncate-toward-zero slicing, parameterised by WORD_SIZE and INT_SLICE. It is reused by any future parallel variant.

Test Plan (IN_SIZE=4, OUT_SIZE=2):
- Basic: X=[0x0100,0x0200,0x0300,0x0400]; W row0 all 0x0100, row1 all 0x0080; B=[0x0080,0x0000] -> Z[0]=0x0A80, Z[1]=0x0500.
- Truncation toward zero: X[0]=0xFF80, W[0][0]=0x0001, other W=0, B[0]=0x0010 -> Z[0]=0x0010 (not 0x000F).
- Wrap: X[0]=0x7F00, W[0][0]=0x0200, others 0, B=0 -> Z[0]=0xFE00.
- Timing: start at edge 0 -> done high after exactly 14 edges for one cycle; exactly 2 z_we pulses at z_addr 0 then 1; busy high throughout; extra start pulses during busy produce no extra writes.
- Reset mid-op: drop rst_n during row1 MAC -> all outputs 0 the same cycle, no Z[1] write. Re-run start -> Basic results reproduced.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer sequencer.
package fc_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_INT_SLICE = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } fc_state_e;

  // Address width for an n-entry memory; a single entry still needs one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Scheduler handshake plus X/W/B read ports and Z write port of one FC layer.
interface fc_layer_sequencer_if
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int IN_SIZE   = 128,
  parameter int OUT_SIZE  = 128
);

  localparam int XW = addr_w(IN_SIZE);
  localparam int WW = addr_w(IN_SIZE * OUT_SIZE);
  localparam int BW = addr_w(OUT_SIZE);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 x_rd_en;
  logic [XW-1:0]        x_addr;
  logic [WORD_SIZE-1:0] x_data;
  logic                 w_rd_en;
  logic [WW-1:0]        w_addr;
  logic [WORD_SIZE-1:0] w_data;
  logic                 b_rd_en;
  logic [BW-1:0]        b_addr;
  logic [WORD_SIZE-1:0] b_data;
  logic                 z_we;
  logic [BW-1:0]        z_addr;
  logic [WORD_SIZE-1:0] z_data;

  // Sequencer side.
  modport master (
    input  start, x_data, w_data, b_data,
    output busy, done, x_rd_en, x_addr, w_rd_en, w_addr,
           b_rd_en, b_addr, z_we, z_addr, z_data
  );

  // Scheduler and memory side.
  modport slave (
    output start, x_data, w_data, b_data,
    input  busy, done, x_rd_en, x_addr, w_rd_en, w_addr,
           b_rd_en, b_addr, z_we, z_addr, z_data
  );

endinterface

// File: rtl/fc_fx_mul.sv
// Signed fixed-point multiply, result truncated toward zero to WORD_SIZE bits.
module fc_fx_mul #(
  parameter int WORD_SIZE = 16,
  parameter int INT_SLICE = 8
) (
  input  logic signed [WORD_SIZE-1:0] i_a,
  input  logic signed [WORD_SIZE-1:0] i_b,
  output logic signed [WORD_SIZE-1:0] o_p
);

  localparam int DEC_SLICE = WORD_SIZE - INT_SLICE;
  localparam int PW        = 2 * WORD_SIZE;

  logic signed [PW-1:0]        w_full;
  logic        [PW-1:0]        w_mag;
  logic        [WORD_SIZE-1:0] w_slice;
  logic                        w_unused_bits;

  assign w_full = PW'(i_a) * PW'(i_b);

  // Slicing the magnitude instead of the raw product makes negative results
  // round toward zero rather than toward minus infinity.
  assign w_mag   = w_full[PW-1] ? -w_full : w_full;
  assign w_slice = w_mag[WORD_SIZE+INT_SLICE-1:DEC_SLICE];
  assign o_p     = w_full[PW-1] ? -w_slice : w_slice;

  // Integer overflow bits and sub-LSB fraction bits are discarded by design.
  assign w_unused_bits = ^{w_mag[PW-1:WORD_SIZE+INT_SLICE], w_mag[DEC_SLICE-1:0]};

endmodule

// File: rtl/fc_layer_sequencer.sv
// Single-lane FC layer: Z[i] = B[i] + sum_j X[j]*W[i][j], streamed from memories.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int INT_SLICE = DEF_INT_SLICE,
  parameter int IN_SIZE   = 128,
  parameter int OUT_SIZE  = 128
) (
  input logic                  clk,
  input logic                  rst_n,
  fc_layer_sequencer_if.master bus
);

  localparam int XW = addr_w(IN_SIZE);
  localparam int WW = addr_w(IN_SIZE * OUT_SIZE);
  localparam int BW = addr_w(OUT_SIZE);

  localparam logic [XW-1:0] J_LAST = XW'(IN_SIZE - 1);
  localparam logic [BW-1:0] I_LAST = BW'(OUT_SIZE - 1);

  fc_state_e            r_state,   w_nxt_state;
  logic [BW-1:0]        r_i,       w_nxt_i;
  logic [XW-1:0]        r_j,       w_nxt_j;
  logic [WORD_SIZE-1:0] r_acc,     w_nxt_acc;
  logic                 r_busy,    w_nxt_busy;
  logic                 r_done,    w_nxt_done;
  logic                 r_x_rd_en, w_nxt_x_rd_en;
  logic [XW-1:0]        r_x_addr,  w_nxt_x_addr;
  logic                 r_w_rd_en, w_nxt_w_rd_en;
  logic [WW-1:0]        r_w_addr,  w_nxt_w_addr;
  logic                 r_b_rd_en, w_nxt_b_rd_en;
  logic [BW-1:0]        r_b_addr,  w_nxt_b_addr;
  logic                 r_z_we,    w_nxt_z_we;
  logic [BW-1:0]        r_z_addr,  w_nxt_z_addr;
  logic [WORD_SIZE-1:0] r_z_data,  w_nxt_z_data;

  logic [WORD_SIZE-1:0] w_prod;
  logic [WW-1:0]        w_row_base;
  logic [XW-1:0]        w_j_inc;

  fc_fx_mul #(
    .WORD_SIZE (WORD_SIZE),
    .INT_SLICE (INT_SLICE)
  ) u_mul (
    .i_a (bus.x_data),
    .i_b (bus.w_data),
    .o_p (w_prod)
  );

  assign w_row_base = WW'(r_i) * WW'(IN_SIZE);
  assign w_j_inc    = r_j + 1'b1;

  // Next state, datapath update and next value of every registered output.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    w_nxt_state   = r_state;
    w_nxt_i       = r_i;
    w_nxt_j       = r_j;
    w_nxt_acc     = r_acc;
    w_nxt_busy    = 1'b0;
    w_nxt_done    = 1'b0;
    w_nxt_x_rd_en = 1'b0;
    w_nxt_x_addr  = '0;
    w_nxt_w_rd_en = 1'b0;
    w_nxt_w_addr  = '0;
    w_nxt_b_rd_en = 1'b0;
    w_nxt_b_addr  = '0;
    w_nxt_z_we    = 1'b0;
    w_nxt_z_addr  = '0;
    w_nxt_z_data  = '0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nxt_state   = LOAD_B;
          w_nxt_i       = '0;
          w_nxt_busy    = 1'b1;
          w_nxt_b_rd_en = 1'b1;
        end
      end
      LOAD_B: begin
        w_nxt_state   = MAC;
        w_nxt_j       = '0;
        w_nxt_busy    = 1'b1;
        w_nxt_x_rd_en = 1'b1;
        w_nxt_w_rd_en = 1'b1;
        w_nxt_w_addr  = w_row_base;
      end
      MAC: begin
        w_nxt_busy = 1'b1;
        // The first MAC cycle sees the bias; later ones see element j-1.
        w_nxt_acc  = (r_j == '0) ? bus.b_data : r_acc + w_prod;
        if (r_j == J_LAST) begin
          w_nxt_state = DRAIN;
        end else begin
          w_nxt_j       = w_j_inc;
          w_nxt_x_rd_en = 1'b1;
          w_nxt_x_addr  = w_j_inc;
          w_nxt_w_rd_en = 1'b1;
          w_nxt_w_addr  = w_row_base + WW'(w_j_inc);
        end
      end
      DRAIN: begin
        w_nxt_state  = WRITE;
        w_nxt_busy   = 1'b1;
        w_nxt_acc    = r_acc + w_prod;
        w_nxt_z_we   = 1'b1;
        w_nxt_z_addr = r_i;
        w_nxt_z_data = w_nxt_acc;
      end
      WRITE: begin
        if (r_i == I_LAST) begin
          w_nxt_state = DONE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_state   = LOAD_B;
          w_nxt_i       = r_i + 1'b1;
          w_nxt_busy    = 1'b1;
          w_nxt_b_rd_en = 1'b1;
          w_nxt_b_addr  = r_i + 1'b1;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // State, counters, accumulator and output registers; reset aborts any layer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_x_rd_en <= 1'b0;
      r_x_addr  <= '0;
      r_w_rd_en <= 1'b0;
      r_w_addr  <= '0;
      r_b_rd_en <= 1'b0;
      r_b_addr  <= '0;
      r_z_we    <= 1'b0;
      r_z_addr  <= '0;
      r_z_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state   <= w_nxt_state;
      r_i       <= w_nxt_i;
      r_j       <= w_nxt_j;
      r_acc     <= w_nxt_acc;
      r_busy    <= w_nxt_busy;
      r_done    <= w_nxt_done;
      r_x_rd_en <= w_nxt_x_rd_en;
      r_x_addr  <= w_nxt_x_addr;
      r_w_rd_en <= w_nxt_w_rd_en;
      r_w_addr  <= w_nxt_w_addr;
      r_b_rd_en <= w_nxt_b_rd_en;
      r_b_addr  <= w_nxt_b_addr;
      r_z_we    <= w_nxt_z_we;
      r_z_addr  <= w_nxt_z_addr;
      r_z_data  <= w_nxt_z_data;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.x_rd_en = r_x_rd_en;
  assign bus.x_addr  = r_x_addr;
  assign bus.w_rd_en = r_w_rd_en;
  assign bus.w_addr  = r_w_addr;
  assign bus.b_rd_en = r_b_rd_en;
  assign bus.b_addr  = r_b_addr;
  assign bus.z_we    = r_z_we;
  assign bus.z_addr  = r_z_addr;
  assign bus.z_data  = r_z_data;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with IN_SIZE=4, OUT_SIZE=2.
module tb_fc_layer_sequencer;

  localparam int IN_SIZE  = 4;
  localparam int OUT_SIZE = 2;

  logic clk;
  logic rst_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] x_mem [IN_SIZE];
  logic [15:0] w_mem [IN_SIZE*OUT_SIZE];
  logic [15:0] b_mem [OUT_SIZE];
  logic [15:0] z_mem [OUT_SIZE];
  int          z_log [8];
  int          z_count;

  fc_layer_sequencer_if #(.WORD_SIZE(16), .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) bus ();

  fc_layer_sequencer #(
    .WORD_SIZE (16),
    .INT_SLICE (8),
    .IN_SIZE   (IN_SIZE),
    .OUT_SIZE  (OUT_SIZE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency read memories; junk when not strobed.
  always @(posedge clk) begin
    bus.x_data <= bus.x_rd_en ? x_mem[bus.x_addr] : 16'hDEAD;
    bus.w_data <= bus.w_rd_en ? w_mem[bus.w_addr] : 16'hBEEF;
    bus.b_data <= bus.b_rd_en ? b_mem[bus.b_addr] : 16'hA5A5;
  end

  // Z memory and write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.z_we) begin
      z_mem[bus.z_addr] = bus.z_data;
      if (z_count < 8) z_log[z_count] = int'(bus.z_addr);
      z_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.busy, bus.done, bus.x_rd_en, bus.x_addr, bus.w_rd_en, bus.w_addr,
                bus.b_rd_en, bus.b_addr, bus.z_we, bus.z_addr, bus.z_data});
  endfunction

  task automatic load(input logic [15:0] x0, x1, x2, x3,
                      input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7,
                      input logic [15:0] b0, b1);
    x_mem = '{x0, x1, x2, x3};
    w_mem = '{w0, w1, w2, w3, w4, w5, w6, w7};
    b_mem = '{b0, b1};
    z_mem = '{16'h0BAD, 16'h0BAD};
  endtask

  // Run one layer; start is sampled at edge 0, done expected after edge 14.
  task automatic run_layer(input bit extra_starts);
    int done_edge;
    int busy_gaps;
    z_count   = 0;
    done_edge = -1;
    busy_gaps = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 200; e++) begin
      bus.start = extra_starts && (e == 4 || e == 9 || e == 13);
      if (!bus.busy) busy_gaps++;
      @(posedge clk); #1;
      if (bus.done) begin
        done_edge = e;
        break;
      end
    end
    check("done_latency", 32'(done_edge), 32'd14);
    check("busy_throughout", 32'(busy_gaps), 32'd0);
    check("busy_low_in_done", 32'(bus.busy), 32'd0);
    // start during DONE must not launch another layer
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("start_in_done_ignored", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("write_count", 32'(z_count), 32'd2);
    check("write_order_0", 32'(z_log[0]), 32'd0);
    check("write_order_1", 32'(z_log[1]), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    z_count   = 0;
    z_log     = '{default: 0};
    load(16'h0100, 16'h0200, 16'h0300, 16'h0400,
         16'h0100, 16'h0100, 16'h0100, 16'h0100,
         16'h0080, 16'h0080, 16'h0080, 16'h0080,
         16'h0080, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", all_outs(), 32'd0);

    // Basic layer with stray start pulses while busy
    run_layer(1'b1);
    check("basic_z0", 32'(z_mem[0]), 32'h0A80);
    check("basic_z1", 32'(z_mem[1]), 32'h0500);

    // Truncation toward zero: -0.5*2^-8 -> 0, and -765/256 -> -2
    load(16'hFF80, 16'hFF01, 16'h0000, 16'h0000,
         16'h0001, 16'h0000, 16'h0000, 16'h0000,
         16'h0000, 16'h0003, 16'h0000, 16'h0000,
         16'h0010, 16'h0000);
    run_layer(1'b0);
    check("trunc_z0", 32'(z_mem[0]), 32'h0010);
    check("trunc_z1", 32'(z_mem[1]), 32'hFFFE);

    // Wrap-around and negative product: 127*2 -> 0xFE00, 1 - 4.5 -> 0xFC80
    load(16'h7F00, 16'hFE80, 16'h0000, 16'h0000,
         16'h0200, 16'h0000, 16'h0000, 16'h0000,
         16'h0000, 16'h0300, 16'h0000, 16'h0000,
         16'h0000, 16'h0100);
    run_layer(1'b0);
    check("wrap_z0", 32'(z_mem[0]), 32'hFE00);
    check("neg_z1", 32'(z_mem[1]), 32'hFC80);

    // Reset during row 1 MAC, then recompute the basic layer
    load(16'h0100, 16'h0200, 16'h0300, 16'h0400,
         16'h0100, 16'h0100, 16'h0100, 16'h0100,
         16'h0080, 16'h0080, 16'h0080, 16'h0080,
         16'h0080, 16'h0000);
    z_count = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("row1_mac_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", all_outs(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_outputs", all_outs(), 32'd0);
    check("reset_write_count", 32'(z_count), 32'd1);
    check("reset_z0_kept", 32'(z_mem[0]), 32'h0A80);
    check("reset_no_z1", 32'(z_mem[1]), 32'h0BAD);
    @(negedge clk);
    rst_n = 1'b1;
    z_mem = '{16'h0BAD, 16'h0BAD};
    run_layer(1'b0);
    check("rerun_z0", 32'(z_mem[0]), 32'h0A80);
    check("rerun_z1", 32'(z_mem[1]), 32'h0500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
